imem_loader: RTL and testbench

- Byte-stream program loader sitting directly upstream of the instruction memory write port (port A).
- Consumes a framed byte stream (from the UART receiver), parses a header, and writes each payload byte into instruction memory with one-hot byte enables.
- Validates the frame with an 8-bit checksum.
- Holds the CPU in reset while a frame is in flight.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader feeding instruction memory port A
//
// Purpose: parses MAGIC, START[31:0], LEN[31:0], LEN payload bytes and CSUM,
// writes each payload byte into instruction memory with a one-hot byte enable,
// checks an 8-bit additive checksum and holds the CPU in reset mid-frame.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    incoming stream byte and its valid
//   in_ready            loader can take a byte (decoded from state)
//   clear               returns DONE/ERR to IDLE
//   imem_ena/wea/addra/dina  registered write port toward instruction memory
//   cpu_hold            high while a frame is in flight
//   done / error        frame accepted / frame rejected (registered)
module imem_loader #(
  parameter logic [7:0] MAGIC     = 8'hA5,
  parameter int         MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic        imem_ena,
  output logic [3:0]  imem_wea,
  output logic [13:0] imem_addra,
  output logic [31:0] imem_dina,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_cnt;
  logic [31:0] r_start;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [7:0]  r_sum;

  logic        r_ena;
  logic [3:0]  r_wea;
  logic [13:0] r_addra;
  logic [31:0] r_dina;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [31:0] w_len_full;
  logic [32:0] w_end;
  logic        w_range_err;
  logic        w_last;
  logic [15:0] w_byte_addr;

  assign w_accept    = in_valid & in_ready;
  // Header bytes arrive little-endian and are shifted in from the top, so the
  // fourth LEN byte completes the value combinationally.
  assign w_len_full  = {in_data, r_len[31:8]};
  // 33-bit sum so START+LEN cannot wrap past the memory size check.
  assign w_end       = {1'b0, r_start} + {1'b0, w_len_full};
  assign w_range_err = (r_start[31:16] != 16'd0) || (w_end > 33'(MEM_BYTES));
  assign w_last      = ((r_idx + 32'd1) == r_len);
  assign w_byte_addr = r_start[15:0] + r_idx[15:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && in_data == MAGIC) w_next = S_ADDR;
      S_ADDR: if (w_accept && r_cnt == 2'd3) w_next = S_LEN;
      S_LEN: begin
        if (w_accept && r_cnt == 2'd3) begin
          if (w_range_err)              w_next = S_ERR;
          else if (w_len_full == 32'd0) w_next = S_CSUM;
          else                          w_next = S_DATA;
        end
      end
      S_DATA: if (w_accept && w_last) w_next = S_CSUM;
      S_CSUM: if (w_accept) w_next = (in_data == r_sum) ? S_DONE : S_ERR;
      S_DONE: if (clear) w_next = S_IDLE;
      S_ERR:  if (clear) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b1;
    cpu_hold = 1'b0;
    case (r_state)
      S_ADDR, S_LEN, S_DATA, S_CSUM: cpu_hold = 1'b1;
      S_DONE, S_ERR:                 in_ready = 1'b0;
      default: ;
    endcase
  end

  // Frame datapath and registered memory write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_start <= 32'd0;
      r_len   <= 32'd0;
      r_idx   <= 32'd0;
      r_sum   <= 8'd0;
      r_ena   <= 1'b0;
      r_wea   <= 4'd0;
      r_addra <= 14'd0;
      r_dina  <= 32'd0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ena   <= 1'b0;
      r_wea   <= 4'd0;
      r_done  <= (w_next == S_DONE);
      r_error <= (w_next == S_ERR);
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (in_data == MAGIC) begin
              r_cnt <= 2'd0;
              r_idx <= 32'd0;
              r_sum <= 8'd0;
            end
          end
          S_ADDR: begin
            r_start <= {in_data, r_start[31:8]};
            r_cnt   <= r_cnt + 2'd1;
          end
          S_LEN: begin
            r_len <= w_len_full;
            r_cnt <= r_cnt + 2'd1;
          end
          S_DATA: begin
            r_ena   <= 1'b1;
            r_wea   <= 4'b0001 << w_byte_addr[1:0];
            r_addra <= w_byte_addr[15:2];
            r_dina  <= {4{in_data}};
            r_sum   <= r_sum + in_data;
            r_idx   <= r_idx + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_ena   = r_ena;
  assign imem_wea   = r_wea;
  assign imem_addra = r_addra;
  assign imem_dina  = r_dina;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic        imem_ena;
  logic [3:0]  imem_wea;
  logic [13:0] imem_addra;
  logic [31:0] imem_dina;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .imem_ena(imem_ena), .imem_wea(imem_wea),
    .imem_addra(imem_addra), .imem_dina(imem_dina), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        ena;
    logic [3:0]  wea;
    logic [13:0] addra;
    logic [31:0] dina;
    logic        hold;
    logic        dn;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t vq[$];
  int   vec_no = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", nm, vec_no, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic clr,
                     input logic ena, input logic [3:0] wea, input logic [13:0] addra,
                     input logic [31:0] dina, input logic hold, input logic dn,
                     input logic err, input logic rdy);
    vec_t t;
    t.v = v; t.d = d; t.clr = clr; t.ena = ena; t.wea = wea; t.addra = addra;
    t.dina = dina; t.hold = hold; t.dn = dn; t.err = err; t.rdy = rdy;
    vq.push_back(t);
  endtask

  task automatic hold_byte(input logic [7:0] d);
    add(1'b1, d, 1'b0, 1'b0, 4'd0, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic idle_byte(input logic [7:0] d);
    add(1'b1, d, 1'b0, 1'b0, 4'd0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic wr(input logic [7:0] d, input logic [13:0] addra, input logic [3:0] wea);
    add(1'b1, d, 1'b0, 1'b1, wea, addra, {4{d}}, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic gap(input logic clr);
    add(1'b0, 8'h00, clr, 1'b0, 4'd0, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic clr_ok();
    add(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic fin_done(input logic [7:0] d);
    add(1'b1, d, 1'b0, 1'b0, 4'd0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic fin_err(input logic [7:0] d);
    add(1'b1, d, 1'b0, 1'b0, 4'd0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  // MAGIC, four START bytes and the first three LEN bytes; caller adds LEN[31:24].
  task automatic hdr(input logic [31:0] start, input logic [31:0] len);
    hold_byte(8'hA5);
    for (int i = 0; i < 4; i++) hold_byte(8'((start >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 3; i++) hold_byte(8'((len >> (8 * i)) & 32'hFF));
  endtask

  task automatic run_queue();
    vec_t t;
    while (vq.size() > 0) begin
      t = vq.pop_front();
      in_valid = t.v; in_data = t.d; clear = t.clr;
      @(posedge clk);
      #1;
      check("imem_ena", 32'(imem_ena), 32'(t.ena));
      check("imem_wea", 32'(imem_wea), 32'(t.wea));
      if (t.ena) begin
        check("imem_addra", 32'(imem_addra), 32'(t.addra));
        check("imem_dina", imem_dina, t.dina);
      end
      check("cpu_hold", 32'(cpu_hold), 32'(t.hold));
      check("done", 32'(done), 32'(t.dn));
      check("error", 32'(error), 32'(t.err));
      check("in_ready", 32'(in_ready), 32'(t.rdy));
      vec_no++;
    end
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_ena", 32'(imem_ena), 32'd0);
    check("rst_wea", 32'(imem_wea), 32'd0);
    check("rst_addra", 32'(imem_addra), 32'd0);
    check("rst_dina", imem_dina, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    #3 rst_n = 1'b1;

    // Normal load, unaligned start 0x102, 5 bytes, checksum 0xFF
    hdr(32'h0000_0102, 32'd5);
    hold_byte(8'h00);
    wr(8'h11, 14'h040, 4'b0100);
    wr(8'h22, 14'h040, 4'b1000);
    wr(8'h33, 14'h041, 4'b0001);
    wr(8'h44, 14'h041, 4'b0010);
    wr(8'h55, 14'h041, 4'b0100);
    fin_done(8'hFF);
    add(1'b1, 8'hA5, 1'b0, 1'b0, 4'd0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_ok();

    // Bad checksum: writes still issued, then ERR
    hdr(32'h0000_0102, 32'd5);
    hold_byte(8'h00);
    wr(8'h11, 14'h040, 4'b0100);
    wr(8'h22, 14'h040, 4'b1000);
    wr(8'h33, 14'h041, 4'b0001);
    wr(8'h44, 14'h041, 4'b0010);
    wr(8'h55, 14'h041, 4'b0100);
    fin_err(8'hFE);
    clr_ok();

    // Range error: 0xFFFE + 3 exceeds 64 KiB
    hdr(32'h0000_FFFE, 32'd3);
    fin_err(8'h00);
    clr_ok();

    // Noise before MAGIC, then a zero-length frame
    idle_byte(8'h00);
    idle_byte(8'h7F);
    hdr(32'd0, 32'd0);
    hold_byte(8'h00);
    fin_done(8'h00);
    clr_ok();

    // Gaps in DATA (clear during a gap is ignored), start 3 crosses a word
    hdr(32'd3, 32'd2);
    hold_byte(8'h00);
    wr(8'h10, 14'h000, 4'b1000);
    gap(1'b0);
    gap(1'b1);
    wr(8'h20, 14'h001, 4'b0001);
    gap(1'b0);
    fin_done(8'h30);
    clr_ok();
    run_queue();

    // Asynchronous reset in the middle of DATA
    hdr(32'd0, 32'd4);
    hold_byte(8'h00);
    wr(8'h11, 14'h000, 4'b0001);
    wr(8'h22, 14'h000, 4'b0010);
    run_queue();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    #1 rst_n = 1'b1;
    idle_byte(8'h11);
    hdr(32'd0, 32'd0);
    hold_byte(8'h00);
    fin_done(8'h00);
    clr_ok();
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
